// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage between ex_mem and mem_wb.
// Decodes loads/stores, issues one byte-enabled request at a time on a
// req/ack data-memory port, aligns and extends load data, and registers every
// result behind a valid/ready output stage.
module mem_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // upstream (ex_mem)
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] instaddr_i,
  input  logic              regs_wen_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [XLEN-1:0]   store_data_i,
  // data memory port
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  // downstream (mem_wb)
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] instaddr_o,
  output logic              regs_wen_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              misalign_o
);

  localparam int         NB       = XLEN / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam bit         IS64     = (XLEN == 64);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, REQ} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  state_e state, state_next;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, f3_legal, mem_op, unsigned_ld, misalign;
  size_e      size;

  // Classify access size/sign and detect misalignment for the current address.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    opcode      = inst_i[6:0];
    funct3      = inst_i[14:12];
    is_load     = (opcode == OP_LOAD);
    is_store    = (opcode == OP_STORE);
    size        = SZ_B;
    unsigned_ld = 1'b0;
    f3_legal    = 1'b0;
    case (funct3)
      3'b000: begin size = SZ_B; f3_legal = 1'b1; end
      3'b001: begin size = SZ_H; f3_legal = 1'b1; end
      3'b010: begin size = SZ_W; f3_legal = 1'b1; end
      3'b011: begin size = SZ_D; f3_legal = IS64; end
      3'b100: begin size = SZ_B; unsigned_ld = 1'b1; f3_legal = is_load; end
      3'b101: begin size = SZ_H; unsigned_ld = 1'b1; f3_legal = is_load; end
      3'b110: begin size = SZ_W; unsigned_ld = 1'b1; f3_legal = is_load && IS64; end
      default: ;
    endcase
    mem_op = (is_load || is_store) && f3_legal;
    case (size)
      SZ_H:    misalign = rd_data_i[0];
      SZ_W:    misalign = |rd_data_i[1:0];
      SZ_D:    misalign = |rd_data_i[2:0];
      default: misalign = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane placement: byte enables, shifted store data, word-aligned address
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     size_mask, be;
  logic [XLEN-1:0]   wdata;
  logic [ADDR_W-1:0] eff_addr, aligned_addr;

  assign off = rd_data_i[OFF_W-1:0];

  // Contiguous byte mask for the access size, before shifting into its lane.
  always_comb begin
    case (size)
      SZ_B:    size_mask = NB'(1);
      SZ_H:    size_mask = NB'(2'b11);
      SZ_W:    size_mask = NB'(4'hF);
      default: size_mask = '1;
    endcase
  end

  assign be    = size_mask << off;
  assign wdata = store_data_i << {off, 3'b000};

  generate
    if (ADDR_W <= XLEN) begin : g_addr_trunc
      assign eff_addr = rd_data_i[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign eff_addr = {{(ADDR_W-XLEN){1'b0}}, rd_data_i};
    end
  endgenerate

  assign aligned_addr = eff_addr & ~ADDR_W'(NB - 1);

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic accept, issue, direct, done;

  // Handshake qualifiers and next-state selection.
  always_comb begin
    state_next = state;
    ready_o    = !rst && (state == IDLE) && (!valid_o || ready_i);
    accept     = valid_i && ready_o;
    issue      = accept && mem_op && !misalign;
    direct     = accept && !issue;
    done       = (state == REQ) && dmem_ack_i;
    case (state)
      IDLE:    if (issue) state_next = REQ;
      REQ:     if (dmem_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request at once.
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Request capture: held stable for the whole REQ phase
  // ---------------------------------------------------------------------------
  logic              req_we, req_load, req_unsigned, req_regs_wen;
  logic [ADDR_W-1:0] req_addr, req_instaddr;
  logic [NB-1:0]     req_be;
  logic [XLEN-1:0]   req_wdata, req_rd_data;
  logic [OFF_W-1:0]  req_off;
  size_e             req_size;
  logic [31:0]       req_inst;
  logic [4:0]        req_rd_addr;

  // Latch request and writeback fields when an aligned access is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we       <= 1'b0;
      req_load     <= 1'b0;
      req_unsigned <= 1'b0;
      req_regs_wen <= 1'b0;
      req_addr     <= '0;
      req_instaddr <= '0;
      req_be       <= '0;
      req_wdata    <= '0;
      req_rd_data  <= '0;
      req_off      <= '0;
      req_size     <= SZ_B;
      req_inst     <= '0;
      req_rd_addr  <= '0;
    end else if (issue) begin
      req_we       <= is_store;
      req_load     <= is_load;
      req_unsigned <= unsigned_ld;
      req_regs_wen <= regs_wen_i && is_load;
      req_addr     <= aligned_addr;
      req_instaddr <= instaddr_i;
      req_be       <= be;
      req_wdata    <= is_store ? wdata : '0;
      req_rd_data  <= rd_data_i;
      req_off      <= off;
      req_size     <= size;
      req_inst     <= inst_i;
      req_rd_addr  <= rd_addr_i;
    end
  end

  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = req_we;
  assign dmem_addr_o  = req_addr;
  assign dmem_be_o    = req_be;
  assign dmem_wdata_o = req_wdata;

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] shifted, load_data;

  assign shifted = dmem_rdata_i >> {req_off, 3'b000};

  // Truncate the lane-shifted word to the access size, then extend.
  always_comb begin
    case (req_size)
      SZ_B: load_data = req_unsigned ? XLEN'(shifted[7:0])
                                     : XLEN'($signed(shifted[7:0]));
      SZ_H: load_data = req_unsigned ? XLEN'(shifted[15:0])
                                     : XLEN'($signed(shifted[15:0]));
      SZ_W: load_data = req_unsigned ? XLEN'(shifted[31:0])
                                     : XLEN'($signed(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register toward mem_wb
  // ---------------------------------------------------------------------------
  // Load from the direct path or a completed access; otherwise hold or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o    <= 1'b0;
      inst_o     <= '0;
      instaddr_o <= '0;
      regs_wen_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
      misalign_o <= 1'b0;
    end else if (direct) begin
      // Any memory opcode reaching this path (misaligned or illegal funct3)
      // must not write the register file.
      valid_o    <= 1'b1;
      inst_o     <= inst_i;
      instaddr_o <= instaddr_i;
      regs_wen_o <= regs_wen_i && !is_load && !is_store;
      rd_addr_o  <= rd_addr_i;
      rd_data_o  <= rd_data_i;
      misalign_o <= mem_op && misalign;
    end else if (done) begin
      valid_o    <= 1'b1;
      inst_o     <= req_inst;
      instaddr_o <= req_instaddr;
      regs_wen_o <= req_regs_wen;
      rd_addr_o  <= req_rd_addr;
      rd_data_o  <= req_load ? load_data : req_rd_data;
      misalign_o <= 1'b0;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu: a vector table for single-cycle
// results plus hand-written multi-cycle sequences, on a 32-bit and a 64-bit
// instance.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- 32-bit instance ----------------
  logic        valid_i, ready_o, regs_wen_i, dmem_req_o, dmem_we_o, dmem_ack_i;
  logic        valid_o, ready_i, regs_wen_o, misalign_o;
  logic [31:0] inst_i, instaddr_i, rd_data_i, store_data_i, dmem_addr_o;
  logic [31:0] dmem_wdata_o, dmem_rdata_i, inst_o, instaddr_o, rd_data_o;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic [3:0]  dmem_be_o;

  mem_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o), .inst_i(inst_i), .instaddr_i(instaddr_i),
    .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .store_data_i(store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .instaddr_o(instaddr_o),
    .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .misalign_o(misalign_o)
  );

  // ---------------- 64-bit instance ----------------
  logic        w_valid_i, w_ready_o, w_regs_wen_i, w_req, w_we, w_ack;
  logic        w_valid_o, w_ready_i, w_regs_wen_o, w_misalign_o;
  logic [31:0] w_inst_i, w_instaddr_i, w_addr, w_inst_o, w_instaddr_o;
  logic [63:0] w_rd_data_i, w_store_data_i, w_wdata, w_rdata, w_rd_data_o;
  logic [4:0]  w_rd_addr_i, w_rd_addr_o;
  logic [7:0]  w_be;

  mem_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .valid_i(w_valid_i), .ready_o(w_ready_o), .inst_i(w_inst_i), .instaddr_i(w_instaddr_i),
    .regs_wen_i(w_regs_wen_i), .rd_addr_i(w_rd_addr_i), .rd_data_i(w_rd_data_i),
    .store_data_i(w_store_data_i),
    .dmem_req_o(w_req), .dmem_we_o(w_we), .dmem_addr_o(w_addr),
    .dmem_be_o(w_be), .dmem_wdata_o(w_wdata), .dmem_ack_i(w_ack),
    .dmem_rdata_i(w_rdata),
    .valid_o(w_valid_o), .ready_i(w_ready_i), .inst_o(w_inst_o), .instaddr_o(w_instaddr_o),
    .regs_wen_o(w_regs_wen_o), .rd_addr_o(w_rd_addr_o), .rd_data_o(w_rd_data_o),
    .misalign_o(w_misalign_o)
  );

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd1, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] rd,
                       input logic [31:0] sd, input logic wen);
    valid_i      = 1'b1;
    inst_i       = inst;
    instaddr_i   = 32'h1000;
    rd_data_i    = rd;
    store_data_i = sd;
    regs_wen_i   = wen;
    rd_addr_i    = 5'd5;
  endtask

  // Byte load at 0x103 with three wait cycles before the ack.
  task automatic byte_load(input logic [2:0] f3, input logic [31:0] exp, input string tag);
    drive(mk(f3, OP_LOAD), 32'h103, 32'h0, 1'b1);
    check({tag, "_accept_ready"}, ready_o, 1'b1);
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_wait_req"}, dmem_req_o, 1'b1);
      check({tag, "_wait_be"}, dmem_be_o, 4'b1000);
      check({tag, "_wait_addr"}, dmem_addr_o, 32'h100);
      check({tag, "_wait_we"}, dmem_we_o, 1'b0);
      check({tag, "_wait_ready"}, ready_o, 1'b0);
      check({tag, "_wait_valid"}, valid_o, 1'b0);
      step();
    end
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h80FF_0000;
    check({tag, "_ack_ready"}, ready_o, 1'b0);
    step();
    dmem_ack_i = 1'b0;
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_data"}, rd_data_o, exp);
    check({tag, "_wen"}, regs_wen_o, 1'b1);
    check({tag, "_rd_addr"}, rd_addr_o, 5'd5);
    check({tag, "_req_dropped"}, dmem_req_o, 1'b0);
    check({tag, "_ready_back"}, ready_o, 1'b1);
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rd_data;
    logic        wen;
    logic [31:0] exp_data;
    logic        exp_wen;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    // Single-cycle results: pass-through, misaligned, illegal funct3.
    vecs[0] = '{mk(3'b000, OP_IMM),   32'h1234, 1'b1, 32'h1234, 1'b1, 1'b0};
    vecs[1] = '{mk(3'b000, OP_IMM),   32'h1234, 1'b1, 32'h1234, 1'b1, 1'b0};
    vecs[2] = '{mk(3'b000, OP_IMM),   32'h1234, 1'b1, 32'h1234, 1'b1, 1'b0};
    vecs[3] = '{mk(3'b010, OP_LOAD),  32'h101,  1'b1, 32'h101,  1'b0, 1'b1};
    vecs[4] = '{mk(3'b001, OP_LOAD),  32'h103,  1'b1, 32'h103,  1'b0, 1'b1};
    vecs[5] = '{mk(3'b010, OP_STORE), 32'h102,  1'b0, 32'h102,  1'b0, 1'b1};
    vecs[6] = '{mk(3'b011, OP_LOAD),  32'h100,  1'b1, 32'h100,  1'b0, 1'b0};
    vecs[7] = '{mk(3'b100, OP_STORE), 32'h40,   1'b0, 32'h40,   1'b0, 1'b0};
    vecs[8] = '{mk(3'b000, OP_IMM),   32'h77,   1'b0, 32'h77,   1'b0, 1'b0};
    vecs[9] = '{mk(3'b101, OP_LOAD),  32'h205,  1'b1, 32'h205,  1'b0, 1'b1};

    valid_i = 0; inst_i = 0; instaddr_i = 0; regs_wen_i = 0; rd_addr_i = 0;
    rd_data_i = 0; store_data_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0; ready_i = 1;
    w_valid_i = 0; w_inst_i = 0; w_instaddr_i = 0; w_regs_wen_i = 0; w_rd_addr_i = 0;
    w_rd_data_i = 0; w_store_data_i = 0; w_ack = 0; w_rdata = 0; w_ready_i = 1;

    // ---- reset state ----
    #12;
    check("rst_ready", ready_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_misalign", misalign_o, 1'b0);
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_addr", dmem_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_ready", ready_o, 1'b1);

    // ---- ack outside REQ is ignored ----
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    check("stray_ack_valid", valid_o, 1'b0);
    check("stray_ack_req", dmem_req_o, 1'b0);

    // ---- table: back-to-back single-cycle results ----
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].inst, vecs[i].rd_data, 32'h0, vecs[i].wen);
      check($sformatf("vec%0d_ready", i), ready_o, 1'b1);
      step();
      check($sformatf("vec%0d_valid", i), valid_o, 1'b1);
      check($sformatf("vec%0d_inst", i), inst_o, vecs[i].inst);
      check($sformatf("vec%0d_data", i), rd_data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_wen", i), regs_wen_o, vecs[i].exp_wen);
      check($sformatf("vec%0d_misalign", i), misalign_o, vecs[i].exp_mis);
      check($sformatf("vec%0d_no_req", i), dmem_req_o, 1'b0);
    end
    valid_i = 1'b0;
    step();
    check("drain_valid", valid_o, 1'b0);

    // ---- LB / LBU with wait states ----
    byte_load(3'b000, 32'hFFFF_FF80, "lb");
    byte_load(3'b100, 32'h0000_0080, "lbu");

    // ---- SH at 0x202, zero-wait memory ----
    drive(mk(3'b001, OP_STORE), 32'h202, 32'h0000_ABCD, 1'b1);
    step();
    valid_i = 1'b0;
    check("sh_req", dmem_req_o, 1'b1);
    check("sh_we", dmem_we_o, 1'b1);
    check("sh_addr", dmem_addr_o, 32'h200);
    check("sh_be", dmem_be_o, 4'b1100);
    check("sh_wdata", dmem_wdata_o, 32'hABCD_0000);
    check("sh_bubble_ready", ready_o, 1'b0);
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    check("sh_valid", valid_o, 1'b1);
    check("sh_wen", regs_wen_o, 1'b0);
    check("sh_req_dropped", dmem_req_o, 1'b0);
    step();

    // ---- back-pressure: result held for 5 cycles, then LW issues ----
    ready_i = 1'b0;
    drive(mk(3'b000, OP_IMM), 32'h55, 32'h0, 1'b1);
    step();
    drive(mk(3'b010, OP_LOAD), 32'h100, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", ready_o, 1'b0);
      check("bp_no_req", dmem_req_o, 1'b0);
      check("bp_valid", valid_o, 1'b1);
      check("bp_data", rd_data_o, 32'h55);
      check("bp_inst", inst_o, mk(3'b000, OP_IMM));
      step();
    end
    ready_i = 1'b1;
    #1;
    check("bp_release_ready", ready_o, 1'b1);
    step();
    valid_i = 1'b0;
    check("bp_drained", valid_o, 1'b0);
    check("bp_lw_req", dmem_req_o, 1'b1);
    check("bp_lw_addr", dmem_addr_o, 32'h100);
    check("bp_lw_be", dmem_be_o, 4'hF);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h1234_5678;
    step();
    dmem_ack_i = 1'b0;
    check("bp_lw_valid", valid_o, 1'b1);
    check("bp_lw_data", rd_data_o, 32'h1234_5678);
    check("bp_lw_wen", regs_wen_o, 1'b1);
    step();

    // ---- 64-bit build: LD and LWU ----
    w_valid_i = 1'b1; w_inst_i = mk(3'b011, OP_LOAD); w_rd_data_i = 64'h8;
    w_regs_wen_i = 1'b1; w_rd_addr_i = 5'd7;
    step();
    w_valid_i = 1'b0;
    check("ld_req", w_req, 1'b1);
    check("ld_addr", w_addr, 32'h8);
    check("ld_be", w_be, 8'hFF);
    w_ack = 1'b1; w_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    w_ack = 1'b0;
    check("ld_valid", w_valid_o, 1'b1);
    check("ld_data", w_rd_data_o, 64'h0123_4567_89AB_CDEF);
    w_valid_i = 1'b1; w_inst_i = mk(3'b110, OP_LOAD); w_rd_data_i = 64'hC;
    step();
    w_valid_i = 1'b0;
    check("lwu_addr", w_addr, 32'h8);
    check("lwu_be", w_be, 8'hF0);
    w_ack = 1'b1; w_rdata = 64'h89AB_CDEF_0123_4567;
    step();
    w_ack = 1'b0;
    check("lwu_data", w_rd_data_o, 64'h0000_0000_89AB_CDEF);
    check("lwu_wen", w_regs_wen_o, 1'b1);
    step();

    // ---- reset pulsed mid-REQ ----
    drive(mk(3'b010, OP_LOAD), 32'h300, 32'h0, 1'b1);
    step();
    valid_i = 1'b0;
    check("rreq_req", dmem_req_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rreq_req_async", dmem_req_o, 1'b0);
    check("rreq_valid", valid_o, 1'b0);
    check("rreq_ready", ready_o, 1'b0);
    check("rreq_addr", dmem_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rreq_after_req", dmem_req_o, 1'b0);
    check("rreq_after_ready", ready_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised, handshaked memory-access stage for the Deilt_RISCV pipeline, sitting between `ex_mem` and `mem_wb`. It decodes loads and stores, drives a byte-enabled request/acknowledge data-memory port with arbitrary wait states, and aligns and sign/zero-extends load data. It registers every result behind a valid/ready output stage and stalls `ex_mem` while a memory access is outstanding. It supersedes the purely combinational load-data select with XLEN-generic access, stores, misalignment detection and back-pressure.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64 (64 enables LWU/LD/SD).
- `ADDR_W`, 32: data-memory address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  `ex_mem` holds a valid instruction.
- `ready_o`  out  1  stage accepts the instruction this cycle.
- `inst_i` / `instaddr_i`  in  32 / ADDR_W  instruction word and PC.
- `regs_wen_i`  in  1  register write-enable; `rd_addr_i` in 5  destination register.
- `rd_data_i`  in  XLEN  ALU result; the effective address for load/store.
- `store_data_i`  in  XLEN  rs2 value for stores.
- `dmem_req_o`  out  1  memory request, held until acknowledged.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  ADDR_W  address aligned to XLEN/8 bytes.
- `dmem_be_o`  out  XLEN/8  byte enables.
- `dmem_wdata_o`  out  XLEN  lane-shifted store data.
- `dmem_ack_i`  in  1  access complete; `dmem_rdata_i` is valid in the same cycle.
- `dmem_rdata_i`  in  XLEN  read data (full aligned word).
- `valid_o`  out  1  output register holds a result; `ready_i` in 1  `mem_wb` accepts it.
- `inst_o`, `instaddr_o`, `regs_wen_o`, `rd_addr_o`, `rd_data_o`  out  as inputs  registered results to `mem_wb`.
- `misalign_o`  out  1  qualifies `valid_o`; the access was misaligned and not issued.

## Operation
- Accept when `valid_i && ready_o`; `ready_o = !rst && state==IDLE && (!valid_o || ready_i)`.
- FSM states:
  - IDLE: accepting. A load/store with an aligned address latches its request fields and moves to REQ. Any other instruction is written directly into the output register.
  - REQ: `dmem_req_o`=1 with all `dmem_*` outputs stable. On `dmem_ack_i`, write the output register and return to IDLE.
- `valid_o` is always 0 while in REQ, because entry requires the output stage to be empty or draining. An ack can therefore never be blocked.
- Load/store decode: load opcode 7'b0000011, store opcode 7'b0100011. funct3 000 B, 001 H, 010 W, 100 BU, 101 HU, 011 D (XLEN=64), 110 WU (XLEN=64).
- Misalignment:
  - H: addr[0]≠0. W: addr[1:0]≠0. D: addr[2:0]≠0.
  - No request is issued; result goes straight to output with `misalign_o`=1 and `regs_wen_o`=0.
- Byte offset `off = addr[log2(XLEN/8)-1:0]`.
  - Stores: `dmem_be_o` = size mask << off; `dmem_wdata_o` = store_data << 8·off.
  - Loads: `dmem_be_o` uses the same mask; result = (`dmem_rdata_i` >> 8·off), truncated to the access size, then sign-extended (B/H/W) or zero-extended (BU/HU/WU) to XLEN.
- Stores force `regs_wen_o`=0. Non-memory instructions pass `rd_data_i` and `regs_wen_i` unchanged.
- `funct3` values illegal for the current XLEN are treated as non-memory pass-through with `regs_wen_o`=0.

## Timing
- Reset (async assert) drives:
  - state=IDLE, `dmem_req_o`=0, `valid_o`=0, `misalign_o`=0.
  - All data and address outputs to 0; `ready_o`=0 while `rst` is high.
- A reset during REQ drops the request immediately. The memory side must tolerate an abandoned request.
- Non-memory instruction or misaligned access: accepted at edge E, `valid_o`=1 after E. Throughput is 1 per cycle when `ready_i`=1.
- Aligned memory access:
  - Accepted at edge E; `dmem_req_o`=1 from E.
  - Ack in cycle k after E produces `valid_o`=1 after edge E+k+1.
  - Zero-wait memory: 2 cycles from accept to `valid_o`, 1 bubble.
- `valid_o` and all output fields hold while `valid_o && !ready_i`.
- `dmem_ack_i` outside REQ is ignored.

## Test plan
- ADDI pass-through, `rd_data_i`=0x1234, `ready_i`=1, back-to-back → `valid_o` each cycle, `rd_data_o`=0x1234, `ready_o` stays 1.
- LB at addr 0x103, `dmem_rdata_i`=0x80FF_0000, ack after 3 wait cycles → `dmem_be_o`=4'b1000, `ready_o`=0 for 4 cycles, `rd_data_o`=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x202, `store_data_i`=0xABCD → `dmem_addr_o`=0x200, `dmem_be_o`=4'b1100, `dmem_wdata_o`=0xABCD_0000, `regs_wen_o`=0.
- LW at 0x101 → no `dmem_req_o`, `valid_o`=1 one cycle later with `misalign_o`=1, `regs_wen_o`=0.
- `ready_i`=0 for 5 cycles with a result held → outputs stable, `ready_o`=0, no new request issued. Release → next LW issues the cycle after the drain.
- `rst` pulsed mid-REQ → `dmem_req_o` falls asynchronously, `valid_o`=0. XLEN=64 build: LD at 0x8 returns the full 64-bit `dmem_rdata_i`.
